axi_lite_test_slave: RTL and testbench
======================================

// Module: axi_lite_test_slave
// PURPOSE
//  AXI4-Lite responder closing the loop for the AXI master test: the other end of the
//  transactions launched by the init pulse. Holds NUM_REGS read/write registers, returns
//  OKAY/SLVERR, and pulses wr_event/rd_event so the bench can tie master tx_done to slave activity.
// PARAMETERS
//  DATA_WIDTH  32  data bus width; must be 32 (byte strobes = DATA_WIDTH/8)
//  ADDR_WIDTH  4   byte address width; word index = addr[ADDR_WIDTH-1:2]
//  NUM_REGS    4   implemented registers; index >= NUM_REGS is out of range
// PORTS
//  clk      in   1             single clock, all logic on posedge
//  rst      in   1             synchronous, active-low reset
//  awaddr   in   ADDR_WIDTH    write address;  awvalid in 1;  awready out 1
//  wdata    in   DATA_WIDTH    write data;     wstrb in 4;  wvalid in 1;  wready out 1
//  bresp    out  2             write response; bvalid out 1;  bready in 1
//  araddr   in   ADDR_WIDTH    read address;   arvalid in 1;  arready out 1
//  rdata    out  DATA_WIDTH    read data;      rresp out 2; rvalid out 1;  rready in 1
//  wr_event out  1             1-cycle pulse when a write response is issued (bvalid rises)
//  rd_event out  1             1-cycle pulse when read data is issued (rvalid rises)
// BEHAVIOUR
//  Reset (rst==0 at posedge): all ready/valid/event outputs 0, bresp=rresp=2'b00, rdata=0,
//   all registers 0, both FSMs to idle. Reset mid-transaction abandons it; no response issued.
//  Write FSM: W_IDLE -> W_RESP -> W_IDLE.
//   W_IDLE: awready=wready=1 for exactly one cycle when awvalid&wvalid both high (address and
//    data accepted together; one without the other is held off). Same edge: write committed.
//   Commit: in-range index -> per-byte update where wstrb[i]=1; bresp=OKAY(00).
//    Out of range -> no register change; bresp=SLVERR(10).
//   W_RESP: bvalid=1 from the cycle after handshake; held (bresp stable) until bready;
//    bvalid&bready -> W_IDLE; next write acceptable the following cycle (min 3 cycles/write).
//  Read FSM: R_IDLE -> R_DATA -> R_IDLE.
//   R_IDLE: arready=1 for one cycle when arvalid; rdata/rresp registered same edge.
//    In range -> register value, OKAY; out of range -> rdata=0, SLVERR.
//   R_DATA: rvalid=1, rdata/rresp stable until rready; rvalid&rready -> R_IDLE.
//  Latency: handshake at edge N -> bvalid/rvalid high after edge N+1 (one cycle). Ready
//   outputs are registered, never combinational from valid inputs.
//  Read and write FSMs independent; both may handshake the same cycle. Same-index collision:
//   read captures the pre-write value; write takes effect after that edge.
//  bready/rready held high in idle: no effect. bready high with bvalid low: ignored.
//  Address bits [1:0] ignored; index bits above log2(NUM_REGS) make the access out of range.
//  wr_event/rd_event: high exactly one cycle, the cycle bvalid/rvalid first go high.
// STRUCTURE
//  Shared package axi_test_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, FSM state encodings
//   (W_IDLE/W_RESP, R_IDLE/R_DATA), shared with the master-side test blocks.
//  One sub-module: axi_test_regfile (NUM_REGS x 32, byte-strobe write port, async read
//   port, in_range flag). FSMs and channel registers stay in the top.
// TESTING
//  1 rst=0 two cycles then release -> all valid/ready 0, reads of idx 0..3 return 0/OKAY.
//  2 write awaddr=4 wdata=32'hDEADBEEF wstrb=4'hF, bready=1 -> bvalid 1 cycle later,
//    bresp=00, wr_event 1 cycle; read araddr=4 -> rdata=32'hDEADBEEF, rresp=00.
//  3 write addr 4 wdata=32'h11223344 wstrb=4'b0101 -> readback 32'hDE22BE44.
//  4 write awaddr=8'h10-equivalent out of range (idx 4, ADDR_WIDTH=5) -> bresp=10, no reg
//    change; read same -> rdata=0, rresp=10.
//  5 bready=0 for 5 cycles after write -> bvalid, bresp stable 5 cycles, aw/wready stay 0;
//    same with rready=0 on read -> rdata stable.
//  6 simultaneous write idx1=32'hA5A5A5A5 and read idx1 (old 0) -> rdata=0; next read
//    32'hA5A5A5A5. Also rst=0 during W_RESP -> bvalid drops next edge, regs cleared.

Source files
------------

// File: rtl/axi_test_pkg.sv
// Shared AXI4-Lite test definitions: response codes, channel FSM state encodings
// and the byte-strobe merge used by the register file.
package axi_test_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_e;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_test_regfile.sv
// NUM_REGS x 32-bit register file: byte-strobed synchronous write port,
// asynchronous read port, and range flags for both index inputs.
module axi_test_regfile
  import axi_test_pkg::*;
#(
  parameter int IDX_W    = 2,
  parameter int NUM_REGS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  output logic             w_in_range,
  input  logic [IDX_W-1:0] ridx,
  output logic [31:0]      rdata,
  output logic             r_in_range
);

  localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [31:0]      regs_q [NUM_REGS];
  logic [31:0]      regs_d [NUM_REGS];
  logic [SEL_W-1:0] wsel_s;
  logic [SEL_W-1:0] rsel_s;

  assign w_in_range = 32'(widx) < 32'(NUM_REGS);
  assign r_in_range = 32'(ridx) < 32'(NUM_REGS);
  assign wsel_s     = widx[SEL_W-1:0];
  assign rsel_s     = ridx[SEL_W-1:0];
  assign rdata      = r_in_range ? regs_q[rsel_s] : 32'h0000_0000;

  // next register contents: only an in-range committed write changes anything
  always_comb begin
    regs_d = regs_q;
    if (we && w_in_range) begin
      regs_d[wsel_s] = strb_merge(regs_q[wsel_s], wdata, wstrb);
    end else begin
      regs_d = regs_q;
    end
  end

  // register storage with synchronous active-low clear
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!rst) begin
        regs_q[i] <= 32'h0000_0000;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule

// File: rtl/axi_lite_test_slave.sv
// AXI4-Lite test responder: independent write and read channel FSMs in front of a
// small register file, with one-cycle event pulses when each response is issued.
module axi_lite_test_slave
  import axi_test_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  output logic                    wr_event,
  output logic                    rd_event
);

  wr_state_e              wr_state_q, wr_state_d;
  rd_state_e              rd_state_q, rd_state_d;
  logic                   awready_q, awready_d;
  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic                   wr_event_q, wr_event_d;
  logic                   arready_q, arready_d;
  logic                   rvalid_q, rvalid_d;
  logic [1:0]             rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   rd_event_q, rd_event_d;
  logic                   wr_commit_s;
  logic                   w_in_range_s;
  logic                   r_in_range_s;
  logic [31:0]            rf_rdata_s;

  axi_test_regfile #(
    .IDX_W    (ADDR_WIDTH - 2),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .we         (wr_commit_s),
    .widx       (awaddr[ADDR_WIDTH-1:2]),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .w_in_range (w_in_range_s),
    .ridx       (araddr[ADDR_WIDTH-1:2]),
    .rdata      (rf_rdata_s),
    .r_in_range (r_in_range_s)
  );

  // write channel: registered ready is raised only once both address and data are
  // presented, so the handshake edge is also the commit edge
  always_comb begin
    wr_state_d  = wr_state_q;
    awready_d   = 1'b0;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    wr_event_d  = 1'b0;
    wr_commit_s = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (awready_q && awvalid && wvalid) begin
          wr_commit_s = 1'b1;
          bvalid_d    = 1'b1;
          bresp_d     = w_in_range_s ? RESP_OKAY : RESP_SLVERR;
          wr_event_d  = 1'b1;
          wr_state_d  = W_RESP;
        end else if (awvalid && wvalid) begin
          awready_d = 1'b1;
        end else begin
          awready_d = 1'b0;
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d   = 1'b0;
          wr_state_d = W_IDLE;
        end else begin
          bvalid_d = 1'b1;
        end
      end
      default: begin
        bvalid_d   = 1'b0;
        wr_state_d = W_IDLE;
      end
    endcase
  end

  // read channel: data is sampled from the register file on the handshake edge,
  // so a same-edge write to the same index is not yet visible
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = 1'b0;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    rd_event_d = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (arready_q && arvalid) begin
          rvalid_d   = 1'b1;
          rdata_d    = rf_rdata_s;
          rresp_d    = r_in_range_s ? RESP_OKAY : RESP_SLVERR;
          rd_event_d = 1'b1;
          rd_state_d = R_DATA;
        end else if (arvalid) begin
          arready_d = 1'b1;
        end else begin
          arready_d = 1'b0;
        end
      end
      R_DATA: begin
        if (rready) begin
          rvalid_d   = 1'b0;
          rd_state_d = R_IDLE;
        end else begin
          rvalid_d = 1'b1;
        end
      end
      default: begin
        rvalid_d   = 1'b0;
        rd_state_d = R_IDLE;
      end
    endcase
  end

  // channel state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_event_q <= 1'b0;
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      rd_event_q <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_event_q <= wr_event_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      rd_event_q <= rd_event_d;
    end
  end

  assign awready  = awready_q;
  assign wready   = awready_q;
  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;
  assign wr_event = wr_event_q;
  assign arready  = arready_q;
  assign rvalid   = rvalid_q;
  assign rresp    = rresp_q;
  assign rdata    = rdata_q;
  assign rd_event = rd_event_q;

endmodule

// File: tb/tb_axi_lite_test_slave.sv
// Randomised self-checking bench for axi_lite_test_slave (ADDR_WIDTH=5 so out-of-range
// indices exist), with a transaction-level register model checked every cycle.
module tb_axi_lite_test_slave;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          awready, wready, bvalid, arready, rvalid, wr_event, rd_event;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;

  int total  = 0;
  int passed = 0;

  // model state: register contents and what each response channel must show
  logic [31:0] mregs [4];
  bit          b_act, r_act, w_hs_last, r_hs_last;
  logic [1:0]  exp_bresp, exp_rresp;
  logic [31:0] exp_rdata;

  axi_lite_test_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .NUM_REGS(4)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .wr_event(wr_event), .rd_event(rd_event)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) mregs[i] = 32'h0;
    b_act = 1'b0; r_act = 1'b0; w_hs_last = 1'b0; r_hs_last = 1'b0;
    exp_bresp = 2'b00; exp_rresp = 2'b00; exp_rdata = 32'h0;
  endfunction

  initial model_reset();

  // compare process: check outputs against the model, then advance the model by
  // the handshakes that the coming posedge will complete
  initial begin
    bit w_hs, r_hs, b_hs, rr_hs;
    int idx;
    forever begin
      @(negedge clk);
      check("bvalid", 32'(bvalid), 32'(b_act));
      check("wr_event", 32'(wr_event), 32'(w_hs_last));
      check("rvalid", 32'(rvalid), 32'(r_act));
      check("rd_event", 32'(rd_event), 32'(r_hs_last));
      if (b_act) begin
        check("bresp", 32'(bresp), 32'(exp_bresp));
        check("awready_busy", 32'(awready), 32'h0);
        check("wready_busy", 32'(wready), 32'h0);
      end
      if (r_act) begin
        check("rdata", rdata, exp_rdata);
        check("rresp", 32'(rresp), 32'(exp_rresp));
        check("arready_busy", 32'(arready), 32'h0);
      end
      w_hs  = awready && wready && awvalid && wvalid;
      b_hs  = bvalid && bready;
      r_hs  = arready && arvalid;
      rr_hs = rvalid && rready;
      w_hs_last = 1'b0;
      r_hs_last = 1'b0;
      if (!rst) begin
        model_reset();
      end else begin
        if (b_hs)  b_act = 1'b0;
        if (rr_hs) r_act = 1'b0;
        if (r_hs) begin
          idx = int'(araddr[AW-1:2]);
          exp_rdata = (idx < 4) ? mregs[idx] : 32'h0;
          exp_rresp = (idx < 4) ? 2'b00 : 2'b10;
          r_act = 1'b1; r_hs_last = 1'b1;
        end
        if (w_hs) begin
          idx = int'(awaddr[AW-1:2]);
          if (idx < 4) begin
            for (int b = 0; b < 4; b++)
              if (wstrb[b]) mregs[idx][8*b +: 8] = wdata[8*b +: 8];
          end
          exp_bresp = (idx < 4) ? 2'b00 : 2'b10;
          b_act = 1'b1; w_hs_last = 1'b1;
        end
      end
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int stall, output logic [1:0] resp);
    int t;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = (stall == 0);
    t = 0;
    while (awready !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
    check("aw_wait", 32'(t < 20), 32'h1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    t = 0;
    while (bvalid !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
    check("b_wait", 32'(t < 20), 32'h1);
    resp = bresp;
    repeat (stall) begin @(posedge clk); #1; end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input int stall,
                    output logic [31:0] d, output logic [1:0] resp);
    int t;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1; rready = (stall == 0);
    t = 0;
    while (arready !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
    check("ar_wait", 32'(t < 20), 32'h1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    t = 0;
    while (rvalid !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
    check("r_wait", 32'(t < 20), 32'h1);
    d = rdata; resp = rresp;
    repeat (stall) begin @(posedge clk); #1; end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r, r2;
    int t;
    rst = 1'b0; awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check("rst_awready", 32'(awready), 32'h0);
    check("rst_arready", 32'(arready), 32'h0);
    check("rst_bvalid", 32'(bvalid), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_bresp", 32'(bresp), 32'h0);
    for (int i = 0; i < 4; i++) begin
      rd(AW'(i * 4), 0, d, r);
      check("rst_read_data", d, 32'h0);
      check("rst_read_resp", 32'(r), 32'h0);
    end

    wr(5'h04, 32'hDEADBEEF, 4'hF, 0, r);
    check("wr_full_resp", 32'(r), 32'h0);
    check("model_idx1", mregs[1], 32'hDEADBEEF);
    rd(5'h04, 0, d, r);
    check("rd_full", d, 32'hDEADBEEF);

    wr(5'h04, 32'h11223344, 4'b0101, 0, r);
    rd(5'h04, 0, d, r);
    check("rd_strobe", d, 32'hDE22BE44);
    check("model_strobe", mregs[1], 32'hDE22BE44);

    wr(5'h10, 32'hFFFFFFFF, 4'hF, 0, r);
    check("wr_oor_resp", 32'(r), 32'h2);
    rd(5'h10, 0, d, r);
    check("rd_oor_data", d, 32'h0);
    check("rd_oor_resp", 32'(r), 32'h2);
    rd(5'h04, 0, d, r);
    check("oor_no_change", d, 32'hDE22BE44);

    wr(5'h0B, 32'h12345678, 4'hF, 5, r);
    check("stall_wr_resp", 32'(r), 32'h0);
    rd(5'h08, 5, d, r);
    check("stall_rd", d, 32'h12345678);

    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    fork
      wr(5'h04, 32'hA5A5A5A5, 4'hF, 0, r);
      rd(5'h04, 0, d, r2);
    join
    check("collide_old", d, 32'h0);
    rd(5'h04, 0, d, r);
    check("collide_new", d, 32'hA5A5A5A5);

    // reset while the write response is pending
    @(posedge clk); #1;
    awaddr = 5'h0C; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    t = 0;
    while (awready !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
    check("midrst_aw_wait", 32'(t < 20), 32'h1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check("midrst_bvalid_hi", 32'(bvalid), 32'h1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_bvalid_lo", 32'(bvalid), 32'h0);
    rst = 1'b1;
    rd(5'h04, 0, d, r);
    check("midrst_idx1", d, 32'h0);
    rd(5'h0C, 0, d, r);
    check("midrst_idx3", d, 32'h0);

    fork
      begin
        logic [1:0] wr_r;
        repeat (40) wr(AW'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
                       $urandom_range(0, 3), wr_r);
      end
      begin
        logic [31:0] rd_d;
        logic [1:0]  rd_r;
        repeat (40) rd(AW'($urandom_range(0, 31)), $urandom_range(0, 3), rd_d, rd_r);
      end
    join

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
